// File: rtl/axi_switch_srl_fifo_pkg.sv
// Shared types and helpers for the SRL-based valid/ready FIFO.
// Optional occupancy output is enabled with AXI_SWITCH_SRL_FIFO_LEVEL_EN.
package axi_switch_srl_fifo_pkg;

    // Controller states: output register empty, output register only, SRL holding beats too
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_OUT   = 2'd1,
        ST_SRL   = 2'd2
    } state_e;

    // Number of entries in one SRL for a given address width
    function automatic int srl_depth(input int a_width);
        return 1 << a_width;
    endfunction

    // Occupancy counter width: must represent 0..DEPTH inclusive
    function automatic int cnt_width(input int a_width);
        return a_width + 1;
    endfunction

endpackage

// File: rtl/axi_switch_srl_fifo_ctrl_bit.sv
// One bit of SRL storage: DEPTH-deep shift register with a random-access read tap.
// Deliberately has no reset so it maps onto SRL primitives.
module axi_switch_srl_bit
    import axi_switch_srl_fifo_pkg::*;
#(
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic [A_WIDTH-1:0] a,
    input  logic               ce,
    input  logic               d,
    output logic               q
);

    localparam int DEPTH = srl_depth(A_WIDTH);

    logic [DEPTH-1:0] srl_q;

    // New bit enters at index 0; older bits move toward higher indices
    always_ff @(posedge clk) begin
        if (ce) begin
            srl_q <= {srl_q[DEPTH-2:0], d};
        end
    end

    assign q = srl_q[a];

endmodule

// File: rtl/axi_switch_srl_fifo_ctrl.sv
// Valid/ready FIFO: SRL storage plus a registered output stage.
// Capacity is DEPTH+1 beats (DEPTH in the SRL, one in the output register).
// Define AXI_SWITCH_SRL_FIFO_LEVEL_EN to add the registered 'level' occupancy port.
module axi_switch_srl_fifo_ctrl
    import axi_switch_srl_fifo_pkg::*;
#(
    parameter int C_WIDTH   = 32,
    parameter int C_A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [C_WIDTH-1:0] s_payload,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [C_WIDTH-1:0] m_payload
`ifdef AXI_SWITCH_SRL_FIFO_LEVEL_EN
   ,output logic [C_A_WIDTH:0] level
`endif
);

    localparam int DEPTH = srl_depth(C_A_WIDTH);
    localparam int CW    = cnt_width(C_A_WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               m_valid_q, m_valid_d;
    logic               s_ready_q, s_ready_d;
    logic [C_WIDTH-1:0] m_payload_q, m_payload_d;

    logic               push;
    logic               pop;
    logic               srl_ce;
    logic [C_A_WIDTH-1:0] srl_addr;
    logic [C_WIDTH-1:0] srl_q;

    assign push = s_valid & s_ready_q;
    assign pop  = m_valid_q & m_ready;

    // Oldest SRL entry sits at cnt-1; the read uses the pre-shift count
    assign srl_addr = C_A_WIDTH'(cnt_q - CW'(1));

    // A beat goes into the SRL whenever it cannot bypass straight into the output register
    assign srl_ce = push & ((state_q == ST_SRL) | ((state_q == ST_OUT) & ~pop));

    // Storage: one SRL per payload bit, all sharing shift enable and read address
    for (genvar i = 0; i < C_WIDTH; i++) begin : g_srl
        axi_switch_srl_bit #(
            .A_WIDTH (C_A_WIDTH)
        ) u_srl_bit (
            .clk (clk),
            .a   (srl_addr),
            .ce  (srl_ce),
            .d   (s_payload[i]),
            .q   (srl_q[i])
        );
    end

    // Next-state, occupancy and output-register load decisions
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_valid_d   = m_valid_q;
        m_payload_d = m_payload_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    m_payload_d = s_payload;
                    m_valid_d   = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (push && pop) begin
                    m_payload_d = s_payload;
                end else if (push) begin
                    cnt_d   = CW'(1);
                    state_d = ST_SRL;
                end else if (pop) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_EMPTY;
                end
            end
            ST_SRL: begin
                if (pop) begin
                    m_payload_d = srl_q;
                    if (!push) begin
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_d = ST_OUT;
                        end
                    end
                end else if (push) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = ST_EMPTY;
                cnt_d     = '0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // Ready depends only on the next count, never on m_ready directly
    always_comb begin
        s_ready_d = (cnt_d != CW'(DEPTH));
    end

    // Control and output registers; SRL contents are intentionally left out of reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= '0;
            m_valid_q   <= 1'b0;
            s_ready_q   <= 1'b0;
            m_payload_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_valid_q   <= m_valid_d;
            s_ready_q   <= s_ready_d;
            m_payload_q <= m_payload_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_payload = m_payload_q;

`ifdef AXI_SWITCH_SRL_FIFO_LEVEL_EN
    logic [CW-1:0] level_q;

    // Total occupancy including the output register, updated alongside cnt
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_q <= '0;
        end else begin
            level_q <= cnt_d + CW'(m_valid_d);
        end
    end

    assign level = level_q;
`endif

`ifndef SYNTHESIS
    // Simulation-only guards against overfill and counter underflow
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(push && srl_ce && (cnt_q == CW'(DEPTH))));
            assert (!(pop && (state_q == ST_SRL) && (cnt_q == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_axi_switch_srl_fifo_ctrl.sv
// Directed bench for axi_switch_srl_fifo_ctrl, default parameters (32-bit payload, 33-beat capacity).
// Level checks are compiled in when AXI_SWITCH_SRL_FIFO_LEVEL_EN is defined.
module tb_axi_switch_srl_fifo_ctrl;

    logic        clk;
    logic        resetn;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_payload;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_payload;
`ifdef AXI_SWITCH_SRL_FIFO_LEVEL_EN
    logic [5:0]  level;
`endif

    int testsRun  = 0;
    int failCount = 0;
    int pushCount = 0;
    int popCount  = 0;
    logic [31:0] sb[$];

    axi_switch_srl_fifo_ctrl #(
        .C_WIDTH   (32),
        .C_A_WIDTH (5)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_payload (s_payload),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_payload (m_payload)
`ifdef AXI_SWITCH_SRL_FIFO_LEVEL_EN
       ,.level     (level)
`endif
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, score handshakes against the reference queue, then advance
    task automatic applyStimulus(input logic sv, input logic [31:0] data, input logic mr);
        logic doPush;
        logic doPop;
        s_valid   = sv;
        s_payload = data;
        m_ready   = mr;
        doPush = sv && s_ready;
        doPop  = m_valid && mr;
        if (doPop) begin
            if (sb.size() == 0) begin
                testsRun++;
                failCount++;
                $error("[TB] FAIL popEmpty observed=pop expected=no beat pending");
            end else begin
                checkOutput("popData", m_payload, sb.pop_front());
            end
            popCount++;
        end
        if (doPush) begin
            sb.push_back(data);
            pushCount++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int q0;

        s_valid   = 1'b0;
        s_payload = '0;
        m_ready   = 1'b0;
        resetn    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstMValid", 32'(m_valid), 32'd0);
        checkOutput("rstSReady", 32'(s_ready), 32'd0);
        checkOutput("rstPayload", m_payload, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("sReadyAfterRst", 32'(s_ready), 32'd1);
`ifdef AXI_SWITCH_SRL_FIFO_LEVEL_EN
        checkOutput("rstLevel", 32'(level), 32'd0);
`endif

        // Single beat, one-cycle latency
        applyStimulus(1'b1, 32'hA5, 1'b1);
        checkOutput("singleMValid", 32'(m_valid), 32'd1);
        checkOutput("singlePayload", m_payload, 32'hA5);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("singleEmpty", 32'(m_valid), 32'd0);

        // Fill: 41 offered with no drain, 33 accepted
        p0 = pushCount;
        for (int i = 0; i <= 40; i++) applyStimulus(1'b1, 32'(i), 1'b0);
        checkOutput("fillAccepted", 32'(pushCount - p0), 32'd33);
        checkOutput("fillSReady", 32'(s_ready), 32'd0);
        checkOutput("fillHead", m_payload, 32'd0);
`ifdef AXI_SWITCH_SRL_FIFO_LEVEL_EN
        checkOutput("fillLevel", 32'(level), 32'd33);
`endif
        q0 = popCount;
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("drainCount", 32'(popCount - q0), 32'd33);
        checkOutput("drainEmpty", 32'(m_valid), 32'd0);

        // Full stream: fill, then push and pop continuously
        for (int i = 0; i < 35; i++) applyStimulus(1'b1, 32'(100 + i), 1'b0);
        checkOutput("refullSReady", 32'(s_ready), 32'd0);
        q0 = popCount;
        for (int i = 0; i < 80; i++) applyStimulus(1'b1, 32'(300 + i), 1'b1);
        checkOutput("fullThroughput", 32'(popCount - q0 >= 40), 32'd1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("fullNoLoss", 32'(sb.size()), 32'd0);
        checkOutput("fullBalance", 32'(pushCount - popCount), 32'd0);

        // Steady push+pop with five beats in the SRL
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'(500 + i), 1'b0);
`ifdef AXI_SWITCH_SRL_FIFO_LEVEL_EN
        checkOutput("steadyLevelStart", 32'(level), 32'd6);
`endif
        p0 = pushCount;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, $urandom, 1'b1);
            checkOutput("steadySReady", 32'(s_ready), 32'd1);
`ifdef AXI_SWITCH_SRL_FIFO_LEVEL_EN
            checkOutput("steadyLevel", 32'(level), 32'd6);
`endif
        end
        checkOutput("steadyPushes", 32'(pushCount - p0), 32'd100);
        q0 = popCount;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("steadyResidue", 32'(popCount - q0), 32'd6);

        // Reset in the middle of operation discards queued beats
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'(700 + i), 1'b0);
        s_valid = 1'b0;
        resetn  = 1'b0;
        #1;
        checkOutput("midRstMValid", 32'(m_valid), 32'd0);
        checkOutput("midRstSReady", 32'(s_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstSReadyBack", 32'(s_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("midRstNoOldData", 32'(m_valid), 32'd0);
        applyStimulus(1'b1, 32'h77, 1'b0);
        checkOutput("postRstPayload", m_payload, 32'h77);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("postRstEmpty", 32'(m_valid), 32'd0);

`ifdef AXI_SWITCH_SRL_FIFO_LEVEL_EN
        // Level sequence: push 3, pop 1
        applyStimulus(1'b1, 32'h1, 1'b0);
        checkOutput("level1", 32'(level), 32'd1);
        applyStimulus(1'b1, 32'h2, 1'b0);
        checkOutput("level2", 32'(level), 32'd2);
        applyStimulus(1'b1, 32'h3, 1'b0);
        checkOutput("level3", 32'(level), 32'd3);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("level4", 32'(level), 32'd2);
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            checkOutput("randLevel", 32'(level), 32'(sb.size()));
        end
`else
        // Random valid/ready traffic against the reference queue
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
`endif
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("randDrained", 32'(sb.size()), 32'd0);
        checkOutput("randFinalEmpty", 32'(m_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
